// File: rtl/memarb_pkg.sv
// Shared encodings and default widths for the two-port memory arbiter.
package memarb_pkg;

  typedef enum logic {
    ST_RR   = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/m_memarb_rr.sv
// Round-robin grant logic for two requesters with a host-exclusive lock input.
// r_last remembers the most recently accepted port; the other port wins a conflict.
module m_memarb_rr
  import memarb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_locked,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_last;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_locked) begin
      o_gnt1 = i_req1;
    end else if (i_req0 && i_req1) begin
      o_gnt0 = (r_last == PORT_HOST);
      o_gnt1 = (r_last == PORT_CPU);
    end else begin
      o_gnt0 = i_req0;
      o_gnt1 = i_req1;
    end
  end

  // Reset to the host so the CPU wins the first conflict.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= PORT_HOST;
    end else if (i_req0 && o_gnt0) begin
      r_last <= PORT_CPU;
    end else if (i_req1 && o_gnt1) begin
      r_last <= PORT_HOST;
    end
  end

endmodule

// File: rtl/m_memarb.sv
// Two-port arbiter/sequencer for a shared single-port memory with a host lock.
// Optional MEMARB_STATS_EN adds saturating conflict and port-0 wait counters.
module m_memarb
  import memarb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_req0,
  input  logic              w_we0,
  input  logic [ADDR_W-1:0] w_addr0,
  input  logic [DATA_W-1:0] w_din0,
  input  logic              w_req1,
  input  logic              w_we1,
  input  logic [ADDR_W-1:0] w_addr1,
  input  logic [DATA_W-1:0] w_din1,
  input  logic              w_lock1,
  output logic              w_gnt0,
  output logic              w_gnt1,
  output logic              r_vld0,
  output logic              r_vld1,
  output logic [DATA_W-1:0] w_rdata,
  output logic              r_locked,
  output logic [ADDR_W-1:0] r_maddr,
  output logic              r_mwe,
  output logic [DATA_W-1:0] r_mdin,
`ifdef MEMARB_STATS_EN
  output logic [31:0]       r_conf_cnt,
  output logic [31:0]       r_wait0_cnt,
`endif
  input  logic [DATA_W-1:0] w_mdout
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_acc0;
  logic   w_acc1;
  logic   r_vld_p0;
  logic   r_port_p0;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) r_state <= ST_RR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RR:   if (w_lock1)  w_state_nxt = ST_LOCK;
      ST_LOCK: if (!w_lock1) w_state_nxt = ST_RR;
      default: w_state_nxt = ST_RR;
    endcase
  end

  assign r_locked = (r_state == ST_LOCK);

  m_memarb_rr u_rr (
    .i_clk    (w_clk),
    .i_rst    (w_rst),
    .i_req0   (w_req0),
    .i_req1   (w_req1),
    .i_locked (r_locked),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1)
  );

  assign w_acc0 = w_req0 & w_gnt0;
  assign w_acc1 = w_req1 & w_gnt1;

  // Stage p0: winning command registered toward the memory.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_maddr <= '0;
      r_mwe   <= 1'b0;
      r_mdin  <= '0;
    end else if (w_acc0) begin
      r_maddr <= w_addr0;
      r_mwe   <= w_we0;
      r_mdin  <= w_din0;
    end else if (w_acc1) begin
      r_maddr <= w_addr1;
      r_mwe   <= w_we1;
      r_mdin  <= w_din1;
    end else begin
      r_mwe   <= 1'b0;
    end
  end

  // Read tag: p0 follows the command, the r_vld stage lines up with w_mdout.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_vld_p0  <= 1'b0;
      r_port_p0 <= PORT_CPU;
      r_vld0    <= 1'b0;
      r_vld1    <= 1'b0;
    end else begin
      r_vld_p0  <= (w_acc0 & ~w_we0) | (w_acc1 & ~w_we1);
      r_port_p0 <= w_acc0 ? PORT_CPU : PORT_HOST;
      r_vld0    <= r_vld_p0 & (r_port_p0 == PORT_CPU);
      r_vld1    <= r_vld_p0 & (r_port_p0 == PORT_HOST);
    end
  end

  assign w_rdata = w_mdout;

`ifdef MEMARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_conf_cnt  <= '0;
      r_wait0_cnt <= '0;
    end else begin
      if (w_req0 && w_req1 && (r_state != ST_LOCK)) r_conf_cnt  <= sat_inc(r_conf_cnt);
      if (w_req0 && !w_gnt0)                        r_wait0_cnt <= sat_inc(r_wait0_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_m_memarb.sv
// Scoreboard bench for m_memarb with a behavioral 4K x 32 registered-read memory.
// Stats counters are checked only when MEMARB_STATS_EN is defined.
module tb_m_memarb;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_req0, w_we0, w_req1, w_we1, w_lock1;
  logic [AW-1:0] w_addr0, w_addr1, r_maddr;
  logic [DW-1:0] w_din0, w_din1, w_rdata, w_mdout, r_mdin;
  logic          w_gnt0, w_gnt1, r_vld0, r_vld1, r_locked, r_mwe;
`ifdef MEMARB_STATS_EN
  logic [31:0]   r_conf_cnt, r_wait0_cnt;
`endif

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  m_memarb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_req0      (w_req0),
    .w_we0       (w_we0),
    .w_addr0     (w_addr0),
    .w_din0      (w_din0),
    .w_req1      (w_req1),
    .w_we1       (w_we1),
    .w_addr1     (w_addr1),
    .w_din1      (w_din1),
    .w_lock1     (w_lock1),
    .w_gnt0      (w_gnt0),
    .w_gnt1      (w_gnt1),
    .r_vld0      (r_vld0),
    .r_vld1      (r_vld1),
    .w_rdata     (w_rdata),
    .r_locked    (r_locked),
    .r_maddr     (r_maddr),
    .r_mwe       (r_mwe),
    .r_mdin      (r_mdin),
`ifdef MEMARB_STATS_EN
    .r_conf_cnt  (r_conf_cnt),
    .r_wait0_cnt (r_wait0_cnt),
`endif
    .w_mdout     (w_mdout)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) begin
    if (r_mwe) mem[r_maddr] <= r_mdin;
    w_mdout <= mem[r_maddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic port, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    exp_t e;
    if (we) begin
      ref_mem[a] = d;
    end else begin
      e.port = port;
      e.data = ref_mem[a];
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic check_out();
    exp_t e;
    chk("vld_onehot", 32'(r_vld0 ^ r_vld1), 32'd1);
    if (sb.size() == 0) begin
      chk("unexpected_vld", {30'd0, r_vld1, r_vld0}, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("vld_port", 32'(r_vld1), 32'(e.port));
      chk("rdata", w_rdata, e.data);
      chk("latency", 32'(cyc - e.cyc), 32'd2);
    end
  endtask

  // Monitor: samples mid-cycle, records accepts and checks returned reads.
  initial begin
    forever begin
      @(negedge w_clk);
      #3;
      cyc++;
      if (!w_rst) begin
        while (sb.size() > 0 && sb[0].cyc + 2 < cyc) begin
          chk("vld_missing", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
        if (w_gnt0 && w_gnt1) chk("gnt_both", 32'd1, 32'd0);
        if (w_req0 && w_gnt0) accept(1'b0, w_we0, w_addr0, w_din0);
        if (w_req1 && w_gnt1) accept(1'b1, w_we1, w_addr1, w_din1);
        if (r_vld0 || r_vld1) check_out();
      end
    end
  end

  task automatic set_in(input logic q0, input logic we0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic q1, input logic we1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge w_clk);
    w_req0 = q0; w_we0 = we0; w_addr0 = a0; w_din0 = d0;
    w_req1 = q1; w_we1 = we1; w_addr1 = a1; w_din1 = d1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) set_in(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    #2;
    chk({tag, "_gnt0"}, 32'(w_gnt0), 32'(g0));
    chk({tag, "_gnt1"}, 32'(w_gnt1), 32'(g1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_maddr"}, 32'(r_maddr), 32'd0);
    chk({tag, "_mwe"}, 32'(r_mwe), 32'd0);
    chk({tag, "_mdin"}, r_mdin, 32'd0);
    chk({tag, "_vld"}, {30'd0, r_vld1, r_vld0}, 32'd0);
    chk({tag, "_locked"}, 32'(r_locked), 32'd0);
  endtask

  logic [DW-1:0] old_val;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     <= 32'hA5A5_0000 | 32'(i);
      ref_mem[i]  = 32'hA5A5_0000 | 32'(i);
    end
    mem[5] <= 32'h0000_1234; ref_mem[5] = 32'h0000_1234;
    mem[1] <= 32'h1111_0001; ref_mem[1] = 32'h1111_0001;
    mem[2] <= 32'h2222_0002; ref_mem[2] = 32'h2222_0002;
    w_rst = 1'b1; w_lock1 = 1'b0;
    w_req0 = 0; w_we0 = 0; w_addr0 = '0; w_din0 = '0;
    w_req1 = 0; w_we1 = 0; w_addr1 = '0; w_din1 = '0;
    repeat (3) @(negedge w_clk);
    chk_reset_vals("rst0");
    w_rst = 1'b0;

    // Dual reads right after reset: CPU wins first, host next cycle.
    set_in(1, 0, 12'd1, '0, 1, 0, 12'd2, '0);
    chk_gnt("dual_a", 1'b1, 1'b0);
    set_in(0, 0, '0, '0, 1, 0, 12'd2, '0);
    chk_gnt("dual_b", 1'b0, 1'b1);
    idle(3);

    // Single CPU read of addr 5.
    set_in(1, 0, 12'd5, '0, 0, 0, '0, '0);
    chk_gnt("single", 1'b1, 1'b0);
    idle(3);

    // Host write then CPU read of the same address.
    set_in(0, 0, '0, '0, 1, 1, 12'd7, 32'h0000_DEAD);
    chk_gnt("wr_host", 1'b0, 1'b1);
    set_in(1, 0, 12'd7, '0, 0, 0, '0, '0);
    chk_gnt("rd_cpu", 1'b1, 1'b0);
    idle(3);

    // Lock: CPU starved while host owns the memory.
    @(negedge w_clk);
    w_lock1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 12'd3, '0, 1, 0, AW'(20 + i), '0);
      chk_gnt("lock", 1'b0, 1'b1);
      chk("lock_state", 32'(r_locked), 32'd1);
    end
    set_in(1, 0, 12'd3, '0, 1, 0, 12'd40, '0);
    w_lock1 = 1'b0;
    chk_gnt("unlock_edge", 1'b0, 1'b1);
    set_in(1, 0, 12'd3, '0, 1, 0, 12'd41, '0);
    chk_gnt("after_unlock", 1'b1, 1'b0);
    chk("unlock_state", 32'(r_locked), 32'd0);
    idle(4);

    // Reset with a read tag in flight: no r_vld must follow.
    set_in(1, 0, 12'd9, '0, 0, 0, '0, '0);
    idle(1);
    #1 w_rst = 1'b1;
    sb.delete();
    #1 chk_reset_vals("rst_rd");
    @(negedge w_clk);
    chk_reset_vals("rst_rd_hold");
    w_rst = 1'b0;
    idle(3);

    // Reset with a write in the command register: r_mwe drops at once.
    old_val = ref_mem[10];
    set_in(0, 0, '0, '0, 1, 1, 12'd10, 32'h0000_BEEF);
    idle(1);
    #1 chk("mwe_pending", 32'(r_mwe), 32'd1);
    w_rst = 1'b1;
    ref_mem[10] = old_val;
    #1 chk_reset_vals("rst_wr");
    @(negedge w_clk);
    w_rst = 1'b0;
    idle(3);
    chk("mem_unchanged", mem[10], old_val);

    // Sustained dual requests alternate strictly, starting with the CPU.
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 12'd30, '0, 1, 0, 12'd31, '0);
      chk_gnt("alt", (i % 2) == 0, (i % 2) == 1);
    end
    idle(1);
`ifdef MEMARB_STATS_EN
    #2;
    chk("conf_cnt", r_conf_cnt, 32'd6);
    chk("wait0_cnt", r_wait0_cnt, 32'd3);
`endif
    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
